flp_relu_bwd: RTL

//  Backward-pass (gradient) unit paired with the forward FP ReLU/leaky ReLU.

---
 rtl/flp_relu_bwd.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/flp_relu_bwd.sv
`default_nettype none
// ============================================================================
//  Module      : flp_relu_bwd
//  Description : Backward-pass gradient gate for the FP ReLU / leaky ReLU.
//                Two-stage valid/ready pipeline. Stage 1 classifies the
//                forward input x. Stage 2 selects between x, g, +0 and
//                g * 2^e.
//  Revision    : 1.0  initial release
// ============================================================================
module flp_relu_bwd #(
   parameter int EWIDTH = 8,
   parameter int SWIDTH = 23
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [EWIDTH+SWIDTH:0]         i_x,
   input  logic [EWIDTH+SWIDTH:0]         i_g,
   input  logic                           i_l,
   input  logic [EWIDTH-2:0]              i_e,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [EWIDTH+SWIDTH:0]         o_r
);

   localparam int W = 1 + EWIDTH + SWIDTH;

   // The exponent sum is kept two bits wider than the exponent field. The
   // largest finite exponent plus the largest leak exponent must not wrap
   // into the negative range, or an overflow would be flushed to zero.
   localparam int TW = EWIDTH + 2;
   localparam logic [TW-1:0] C_T_INF = TW'((1 << EWIDTH) - 1);

   // Pipeline advance terms. o_ready is combinational from i_ready because
   // there is no skid buffer.
   logic adv1;
   logic adv2;

   // Stage 1 registers
   logic                v1_q,    v1_d;
   logic [W-1:0]        x1_q,    x1_d;
   logic [W-1:0]        g1_q,    g1_d;
   logic                xnan1_q, xnan1_d;
   logic                xpos1_q, xpos1_d;
   logic                l1_q,    l1_d;
   logic [EWIDTH-2:0]   e1_q,    e1_d;

   // Stage 2 registers
   logic                v2_q,    v2_d;
   logic [W-1:0]        r_q,     r_d;

   // Classification of the incoming x
   logic                x_exp_ones;
   logic                x_exp_zero;
   logic                x_frac_nz;
   logic                x_nan;
   logic                x_pos;

   // Stage 2 selection terms
   logic                g_sign;
   logic [EWIDTH-1:0]   g_exp;
   logic [SWIDTH-1:0]   g_frac;
   logic                g_nan;
   logic [TW-1:0]       t_sum;
   logic [W-1:0]        scaled;
   logic [W-1:0]        sel;

   // Handshake: a stage may load when it is empty or its content moves on.
   always_comb begin
      adv2    = ~v2_q | i_ready;
      adv1    = ~v1_q | adv2;
      o_ready = adv1;
      o_valid = v2_q;
      o_r     = r_q;
   end

   // Forward-input classification. Zero and denormal x (exponent field zero)
   // are treated as non-positive regardless of sign; +inf is positive.
   always_comb begin
      x_exp_ones = &i_x[W-2:SWIDTH];
      x_exp_zero = ~|i_x[W-2:SWIDTH];
      x_frac_nz  = |i_x[SWIDTH-1:0];
      x_nan      = x_exp_ones & x_frac_nz;
      x_pos      = ~i_x[W-1] & ~x_nan & ~x_exp_zero;
   end

   // Stage 1 next state: capture x, its class, and g/l/e when accepting.
   always_comb begin
      v1_d    = v1_q;
      x1_d    = x1_q;
      g1_d    = g1_q;
      xnan1_d = xnan1_q;
      xpos1_d = xpos1_q;
      l1_d    = l1_q;
      e1_d    = e1_q;
      if (adv1) begin
         v1_d = i_valid;
         if (i_valid) begin
            x1_d    = i_x;
            g1_d    = i_g;
            xnan1_d = x_nan;
            xpos1_d = x_pos;
            l1_d    = i_l;
            e1_d    = i_e;
         end
      end
   end

   // Leaky scaling g * 2^e with flush-to-zero on underflow and inf on overflow.
   always_comb begin
      g_sign = g1_q[W-1];
      g_exp  = g1_q[W-2:SWIDTH];
      g_frac = g1_q[SWIDTH-1:0];
      g_nan  = (&g_exp) & (|g_frac);
      t_sum  = {2'b00, g_exp} + {{3{e1_q[EWIDTH-2]}}, e1_q};
      if (g_exp == '0) begin
         scaled = {g_sign, {(W-1){1'b0}}};
      end else if (&g_exp) begin
         scaled = g1_q;
      end else if (t_sum[TW-1] || (t_sum == '0)) begin
         scaled = {g_sign, {(W-1){1'b0}}};
      end else if (t_sum >= C_T_INF) begin
         scaled = {g_sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
      end else begin
         scaled = {g_sign, t_sum[EWIDTH-1:0], g_frac};
      end
   end

   // Result select in priority order: x NaN, g NaN, positive x, ReLU, leaky.
   always_comb begin
      if (xnan1_q) begin
         sel = x1_q;
      end else if (g_nan) begin
         sel = g1_q;
      end else if (xpos1_q) begin
         sel = g1_q;
      end else if (!l1_q) begin
         sel = '0;
      end else begin
         sel = scaled;
      end
   end

   // Stage 2 next state: take the stage-1 beat when the output side moves.
   always_comb begin
      v2_d = v2_q;
      r_d  = r_q;
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            r_d = sel;
         end
      end
   end

   // Pipeline registers; reset drops every in-flight beat.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v1_q    <= 1'b0;
         x1_q    <= '0;
         g1_q    <= '0;
         xnan1_q <= 1'b0;
         xpos1_q <= 1'b0;
         l1_q    <= 1'b0;
         e1_q    <= '0;
         v2_q    <= 1'b0;
         r_q     <= '0;
      end else begin
         v1_q    <= v1_d;
         x1_q    <= x1_d;
         g1_q    <= g1_d;
         xnan1_q <= xnan1_d;
         xpos1_q <= xpos1_d;
         l1_q    <= l1_d;
         e1_q    <= e1_d;
         v2_q    <= v2_d;
         r_q     <= r_d;
      end
   end

endmodule
`default_nettype wire
